// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the core memory stage and a word-wide,
//   byte-addressed data memory. Handles one RV32I load/store at a time.
//   Sub-word stores are performed as an aligned read-modify-write.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   req_*               request handshake (valid/ready), we, funct3, addr,
//                       wdata
//   rsp_*               one-cycle response pulse with load data / error flag
//   mem_*               word-aligned memory port; mem_data_i is combinational
//                       read data
//
// DWIDTH must be 32; the lane arithmetic assumes four byte lanes.
// ---------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h00100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    // Highest legal word-aligned address.
    localparam logic [AWIDTH-1:0] LAST_WORD = BASE_ADDR + MEM_BYTES - AWIDTH'(4);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

    state_e              state_q, state_d;
    logic [1:0]          off_q, off_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   word_q, word_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;

    logic                accept;
    logic                req_err;
    logic [AWIDTH-1:0]   req_aligned;
    logic [DWIDTH-1:0]   merged;
    logic [DWIDTH-1:0]   load_data;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;

    // Request legality, evaluated on the live request inputs at acceptance.
    always_comb begin
        req_aligned = {req_addr_i[AWIDTH-1:2], 2'b00};
        req_err     = 1'b0;
        if (req_funct3_i[1:0] == 2'd1 && req_addr_i[0])
            req_err = 1'b1;
        if (req_funct3_i[1:0] == 2'd2 && req_addr_i[1:0] != 2'd0)
            req_err = 1'b1;
        if (req_addr_i < BASE_ADDR || req_aligned > LAST_WORD)
            req_err = 1'b1;
        if (!req_we_i && (req_funct3_i == 3'd3 || req_funct3_i == 3'd6 ||
                          req_funct3_i == 3'd7))
            req_err = 1'b1;
        if (req_we_i && req_funct3_i > 3'd2)
            req_err = 1'b1;
    end

    assign accept = req_valid_i & req_ready_o;

    // Next-state and datapath register updates.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        word_d     = word_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d    = req_addr_i[1:0];
                    funct3_d = req_funct3_i;
                    we_d     = req_we_i;
                    wdata_d  = req_wdata_i;
                    err_d    = req_err;
                    if (req_err) begin
                        // Rejected requests never touch the memory port,
                        // so the address bus keeps its previous value.
                        state_d = RESP;
                    end else begin
                        mem_addr_d = req_aligned;
                        state_d    = (req_we_i && req_funct3_i == 3'd2) ? WR : RD;
                    end
                end
            end
            RD: begin
                // Old word: load source, or merge base for SB/SH.
                word_d  = mem_data_i;
                state_d = we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store merge: only SB/SH splice into the captured word; SW writes wdata.
    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'd0:    merged[{off_q, 3'b000} +: 8]      = wdata_q[7:0];
            2'd1:    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load extraction from the captured word.
    always_comb begin
        lane_b = word_q[{off_q, 3'b000} +: 8];
        lane_h = word_q[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'd0:    load_data = {{(DWIDTH-8){lane_b[7]}}, lane_b};
            3'd1:    load_data = {{(DWIDTH-16){lane_h[15]}}, lane_h};
            3'd2:    load_data = word_q;
            3'd4:    load_data = {{(DWIDTH-8){1'b0}}, lane_b};
            3'd5:    load_data = {{(DWIDTH-16){1'b0}}, lane_h};
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            off_q      <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            word_q     <= '0;
            mem_addr_q <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            funct3_q   <= funct3_d;
            we_q       <= we_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            word_q     <= word_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Every output is gated by rst so an in-flight write is dropped
    // combinationally the moment reset asserts.
    assign req_ready_o    = rst & (state_q == IDLE);
    assign rsp_valid_o    = rst & (state_q == RESP);
    assign rsp_err_o      = rsp_valid_o & err_q;
    assign rsp_rdata_o    = (rsp_valid_o & ~err_q & ~we_q) ? load_data : '0;
    assign mem_read_en_o  = rst & (state_q == RD);
    assign mem_write_en_o = rst & (state_q == WR);
    assign mem_data_o     = mem_write_en_o ? merged : '0;
    assign mem_addr_o     = rst ? mem_addr_q : BASE_ADDR;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    localparam logic [31:0] BASE = 32'h01000000;
    localparam logic [31:0] MEMB = 32'h00100000;
    localparam int          NWORDS = 262144;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;

    lsu_mem_master dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_read_en_o  (mem_read_en_o),
        .mem_write_en_o (mem_write_en_o),
        .mem_data_i     (mem_data_i)
    );

    always #5 clk = ~clk;

    // Environment memory (word array covering the whole data region).
    bit [31:0]   mem [0:NWORDS-1];
    logic        poke_en = 1'b0;
    logic [17:0] poke_idx = '0;
    logic [31:0] poke_val = '0;

    assign mem_data_i = mem[mem_addr_o[19:2]];

    always @(posedge clk) begin
        if (poke_en)             mem[poke_idx] <= poke_val;
        else if (mem_write_en_o) mem[mem_addr_o[19:2]] <= mem_data_o;
    end

    // Reference model state.
    bit [31:0] ref_mem [0:NWORDS-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 18'(idx);
        poke_val = val;
        @(negedge clk);
        poke_en  = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference behaviour from the ISA rules: error, load value, latency,
    // which enables should appear and the word a store should leave behind.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output bit err, output logic [31:0] rdata,
                         output int lat, output bit rd_en, output bit wr_en,
                         output logic [31:0] wword);
        int unsigned size, off, idx;
        logic [31:0] old, v, b, h, mask;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                                      f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err   = !legal || (a % size != 0) || (a < BASE) ||
                ((a & ~32'd3) > BASE + MEMB - 32'd4);
        rdata = '0; wword = '0; rd_en = 1'b0; wr_en = 1'b0; lat = 1;
        if (!err) begin
            off = a % 4;
            idx = (a - BASE) / 4;
            old = ref_mem[idx];
            if (!we) begin
                lat = 2; rd_en = 1'b1;
                v = old >> (8 * off);
                b = v & 32'hFF;
                h = v & 32'hFFFF;
                case (f3)
                    3'd0:    rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                    3'd1:    rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd4:    rdata = b;
                    3'd5:    rdata = h;
                    default: rdata = old;
                endcase
            end else begin
                wr_en = 1'b1;
                rd_en = (f3 != 3'd2);
                lat   = (f3 == 3'd2) ? 2 : 3;
                mask  = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
                wword = (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
                ref_mem[idx] = wword;
            end
        end
    endtask

    // One request, observed cycle by cycle until its response.
    task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag,
                           output logic [31:0] obs);
        bit e_err, e_rd, e_wr, s_rd, s_wr, got;
        logic [31:0] e_data, e_word;
        int e_lat, lat, w;
        model(we, f3, a, wd, e_err, e_data, e_lat, e_rd, e_wr, e_word);
        @(negedge clk);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
        w = 0;
        while (!req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        s_rd = 1'b0; s_wr = 1'b0; got = 1'b0; lat = 0; obs = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (c > 1) @(negedge clk);
            if (mem_read_en_o) begin
                s_rd = 1'b1;
                chk({tag, "_raddr"}, mem_addr_o, a & ~32'd3);
            end
            if (mem_write_en_o) begin
                s_wr = 1'b1;
                chk({tag, "_waddr"}, mem_addr_o, a & ~32'd3);
                chk({tag, "_wdata"}, mem_data_o, e_word);
            end
            if (rsp_valid_o) begin
                got = 1'b1;
                lat = c;
                obs = rsp_rdata_o;
                chk({tag, "_err"}, 32'(rsp_err_o), 32'(e_err));
                chk({tag, "_rdata"}, rsp_rdata_o, e_data);
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
        chk({tag, "_rden"}, 32'(s_rd), 32'(e_rd));
        chk({tag, "_wren"}, 32'(s_wr), 32'(e_wr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] eq[$];
        logic [31:0] cur_a, e_data, e_word;
        bit e_err, e_rd, e_wr, pend, rsp_seen;
        int e_lat, acc, nrsp, last, nbad;
        logic [2:0] lf [5];
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_ready",  32'(req_ready_o),    32'd0);
        chk("rst_rspv",   32'(rsp_valid_o),    32'd0);
        chk("rst_err",    32'(rsp_err_o),      32'd0);
        chk("rst_rdata",  rsp_rdata_o,         32'd0);
        chk("rst_rden",   32'(mem_read_en_o),  32'd0);
        chk("rst_wren",   32'(mem_write_en_o), 32'd0);
        chk("rst_mdata",  mem_data_o,          32'd0);
        chk("rst_maddr",  mem_addr_o,          BASE);
        poke(1, 32'hDEADBEEF);
        poke(2, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;

        // Directed loads.
        run_req(0, 3'd2, 32'h01000004, 0, "lw", obs);
        chk("lw_val", obs, 32'hDEADBEEF);
        run_req(0, 3'd0, 32'h01000007, 0, "lb", obs);
        chk("lb_val", obs, 32'hFFFFFFDE);
        run_req(0, 3'd4, 32'h01000007, 0, "lbu", obs);
        chk("lbu_val", obs, 32'h000000DE);
        run_req(0, 3'd1, 32'h01000006, 0, "lh", obs);
        chk("lh_val", obs, 32'hFFFFDEAD);
        run_req(0, 3'd5, 32'h01000006, 0, "lhu", obs);
        chk("lhu_val", obs, 32'h0000DEAD);

        // Read-modify-write stores.
        run_req(1, 3'd0, 32'h01000005, 32'h12345678, "sb", obs);
        run_req(0, 3'd2, 32'h01000004, 0, "sb_lw", obs);
        chk("sb_word", obs, 32'hDEAD78EF);
        run_req(1, 3'd2, 32'h01000004, 32'hDEADBEEF, "sw", obs);
        run_req(1, 3'd1, 32'h01000006, 32'hAAAA5555, "sh", obs);
        run_req(0, 3'd2, 32'h01000004, 0, "sh_lw", obs);
        chk("sh_word", obs, 32'h5555BEEF);

        // Error cases and boundaries.
        run_req(0, 3'd1, 32'h01000001, 0, "e_lh", obs);
        run_req(0, 3'd2, 32'h00FFFFFC, 0, "e_low", obs);
        run_req(1, 3'd2, 32'h01100000, 32'h55, "e_high", obs);
        run_req(0, 3'd3, 32'h01000004, 0, "e_f3", obs);
        run_req(1, 3'd5, 32'h01000004, 32'h1, "e_sf3", obs);
        run_req(1, 3'd2, 32'h010FFFFC, 32'hA5A5F00F, "last_sw", obs);
        run_req(0, 3'd0, 32'h010FFFFF, 0, "last_lb", obs);

        // Back-to-back LWs with valid held high.
        cur_a = BASE + 4 * $urandom_range(0, 7);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd2;
        req_addr_i = cur_a; req_wdata_i = '0;
        acc = 0; nrsp = 0; last = -1; pend = 1'b0;
        for (int c = 0; c < 60 && nrsp < 6; c++) begin
            @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (acc < 6) begin
                    cur_a = BASE + 4 * $urandom_range(0, 7);
                    req_addr_i = cur_a;
                end else begin
                    req_valid_i = 1'b0;
                end
            end
            if (rsp_valid_o) begin
                if (eq.size() > 0) chk("strm_rdata", rsp_rdata_o, eq.pop_front());
                else chk("strm_extra", 32'd1, 32'd0);
                nrsp++;
            end
            if (mem_read_en_o || rsp_valid_o) chk("strm_busy", 32'(req_ready_o), 32'd0);
            if (req_valid_i && req_ready_o) begin
                if (last >= 0) chk("strm_gap", 32'(c - last), 32'd3);
                last = c;
                model(0, 3'd2, cur_a, 0, e_err, e_data, e_lat, e_rd, e_wr, e_word);
                eq.push_back(e_data);
                acc++;
                pend = 1'b1;
            end
        end
        req_valid_i = 1'b0;
        chk("strm_count", 32'(nrsp), 32'd6);

        // Reset asserted during the write cycle of a SW.
        @(negedge clk);
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2;
        req_addr_i = 32'h01000008; req_wdata_i = 32'h11223344;
        chk("ra_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("ra_inwr", 32'(mem_write_en_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("ra_wren",  32'(mem_write_en_o), 32'd0);
        chk("ra_mdata", mem_data_o, 32'd0);
        chk("ra_maddr", mem_addr_o, BASE);
        rsp_seen = rsp_valid_o;
        @(negedge clk);
        rsp_seen = rsp_seen | rsp_valid_o;
        rst = 1'b1;
        #1;
        chk("ra_ready_after", 32'(req_ready_o), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rsp_seen = rsp_seen | rsp_valid_o;
        end
        chk("ra_norsp", 32'(rsp_seen), 32'd0);
        chk("ra_mem", mem[2], ref_mem[2]);

        // Randomized mix against the model.
        for (int i = 0; i < 80; i++) begin
            bit we;
            logic [2:0] f3;
            logic [31:0] a;
            int sel;
            we  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = lf[$urandom_range(0, 4)];
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = BASE - 32'($urandom_range(1, 8));
            else if (sel == 1) a = BASE + MEMB - 32'd8 + 32'($urandom_range(0, 11));
            else               a = BASE + 32'($urandom_range(0, 127));
            run_req(we, f3, a, $urandom, "rnd", obs);
        end

        nbad = 0;
        for (int i = 0; i < 40; i++) if (mem[i] != ref_mem[i]) nbad++;
        for (int i = NWORDS - 4; i < NWORDS; i++) if (mem[i] != ref_mem[i]) nbad++;
        chk("mem_final", 32'(nbad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the core's memory stage and the byte-addressable data memory.
- Accepts one RV32I load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives the memory's word-wide read/write port. Sub-word stores are done as aligned read-modify-write.
- Returns sign/zero-extended load data, or an error for misaligned, out-of-range or illegal requests.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; only 32 is supported.
- BASE_ADDR, 32'h01000000, first byte address of data memory.
- MEM_BYTES, 32'h00100000, memory size in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3.
- req_addr_i  in  AWIDTH  byte address.
- req_wdata_i  in  DWIDTH  store data; low bytes are used for SB/SH.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DWIDTH  load result; 0 for stores and errors.
- rsp_err_o  out  1  request rejected; valid with rsp_valid_o.
- mem_addr_o  out  AWIDTH  word-aligned memory address.
- mem_data_o  out  DWIDTH  memory write data.
- mem_read_en_o  out  1  memory read enable.
- mem_write_en_o  out  1  memory write enable.
- mem_data_i  in  DWIDTH  combinational memory read data.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst: state goes to IDLE at the first posedge with rst=0.
- Values while rst=0:
  - req_ready_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - mem_read_en_o=0, mem_write_en_o=0, mem_data_o=0, mem_addr_o=BASE_ADDR.
- Memory enables are gated by rst, so no memory write occurs on any edge where rst=0.
- FSM states: IDLE, RD, WR, RESP.
- req_ready_o = (state==IDLE) & rst. A request is accepted on a posedge with req_valid_i & req_ready_o. Addr, funct3, we and wdata are registered at acceptance.
- Error conditions, checked at acceptance; if any holds: IDLE→RESP, no memory enable ever asserted, rsp_err_o=1.
  - Halfword op with addr[0]=1.
  - Word op with addr[1:0]!=0.
  - addr<BASE_ADDR, or aligned addr > BASE_ADDR+MEM_BYTES-4.
  - Illegal load funct3: 3, 6, 7.
  - Illegal store funct3: >2.
- Legal load: IDLE→RD→RESP.
  - In RD: mem_read_en_o=1, mem_addr_o = addr & ~3. mem_data_i is registered at end of RD.
- Legal SW: IDLE→WR→RESP.
  - In WR: mem_write_en_o=1, mem_data_o=wdata.
- Legal SB/SH: IDLE→RD→WR→RESP.
  - RD captures the old word.
  - WR writes the merged word to the same aligned address.
- Latencies from the accept edge T: error T+1, load T+2, SW T+2, SB/SH T+3.
- RESP lasts exactly one cycle with rsp_valid_o=1, then →IDLE. A new request can be accepted on the edge ending the RESP cycle's successor IDLE cycle, i.e. there is one bubble.
- Byte lane: off = addr[1:0].
  - SB replaces lane off with wdata[7:0].
  - SH replaces lanes off and off+1 with wdata[15:0].
  - Other lanes keep the old word.
- Load extraction from the captured word:
  - LB: sign-extend lane off.
  - LBU: zero-extend lane off.
  - LH: sign-extend halfword at off.
  - LHU: zero-extend halfword at off.
  - LW: whole word.
- rsp_rdata_o is 0 for stores and errors.
- mem_addr_o holds its last value when enables are low. mem_data_o is 0 outside WR.
- Requests are not queued; req_valid_i while not ready is ignored and must be held by the source.
- rst=0 in any state aborts the operation: no write is performed and no response is issued.

Test Plan:
1. Memory word at 0x01000004 = 0xDEADBEEF. LW 0x01000004 accepted at T → RD at T+1 with mem_addr_o=0x01000004; rsp_valid_o at T+2 with rdata 0xDEADBEEF, err=0.
2. Same word:
   - LB 0x01000007 → 0xFFFFFFDE.
   - LBU 0x01000007 → 0x000000DE.
   - LH 0x01000006 → 0xFFFFDEAD.
   - LHU 0x01000006 → 0x0000DEAD.
3. SB 0x01000005, wdata 0x12345678, over 0xDEADBEEF:
   - T+1 read.
   - T+2 write of 0xDEAD78EF.
   - T+3 rsp err=0.
   - A following LW returns 0xDEAD78EF.
   - Also SH 0x01000006, wdata 0xAAAA5555 → 0x5555BEEF.
4. Errors:
   - LH 0x01000001, LW 0x00FFFFFC and SW 0x01100000 each give rsp at T+1 with err=1, rdata 0, and mem_read_en_o/mem_write_en_o never high.
   - Load with funct3=3 gives the same error response.
5. req_valid_i held high with a stream of LWs: req_ready_o=0 in RD/RESP; accepts occur every 3 cycles; responses are in order with the correct data.
6. rst=0 during the WR cycle of SW 0x01000008 data 0x11223344:
   - mem_write_en_o=0 and the memory is unchanged.
   - No rsp_valid_o.
   - req_ready_o=1 in the first cycle after rst returns to 1.
